// File: rtl/mux_arbiter_2to1_if.sv
// mux_arbiter_2to1_if: request/data/grant bundle between two requesters and the arbiter
// master: requester side (drives Req/Hyrja/Done, observes Gnt/S/Dalja/Valid)
// slave:  arbiter side (the reverse)
interface mux_arbiter_2to1_if;
  logic       Req0;
  logic       Req1;
  logic [3:0] Hyrja0;
  logic [3:0] Hyrja1;
  logic       Done0;
  logic       Done1;
  logic       Gnt0;
  logic       Gnt1;
  logic       S;
  logic [3:0] Dalja;
  logic       Valid;
  modport master (
    output Req0, Req1, Hyrja0, Hyrja1, Done0, Done1,
    input  Gnt0, Gnt1, S, Dalja, Valid
  );
  modport slave (
    input  Req0, Req1, Hyrja0, Hyrja1, Done0, Done1,
    output Gnt0, Gnt1, S, Dalja, Valid
  );
endinterface

// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1: two-requester round-robin arbiter with hold limit and registered 4-bit data mux
// Clock  : rising-edge clock
// Resetn : asynchronous active-low reset
// bus    : slave side of mux_arbiter_2to1_if (Req/Hyrja/Done in, Gnt/S/Dalja/Valid out)
module mux_arbiter_2to1 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  mux_arbiter_2to1_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam logic [3:0] HOLD_TOP = 4'(MAX_HOLD - 1);
  state_t     st_q, st_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       hit, rel0, rel1, entry;
  logic       gnt0_q, gnt1_q;
  logic       s_q, s_d;
  logic [3:0] dalja_q, dalja_d;
  logic       valid_q, valid_d;
  // The forced switch fires on the edge where the counter arrives at (or sits
  // saturated on) HOLD_TOP, so a holder gets at most MAX_HOLD-1 cycles while
  // the other side waits.
  always_comb begin
    cnt_inc = (cnt_q == HOLD_TOP) ? cnt_q : cnt_q + 4'd1;
    hit     = (cnt_inc == HOLD_TOP);
    rel0    = bus.Done0 || !bus.Req0 || (hit && bus.Req1);
    rel1    = bus.Done1 || !bus.Req1 || (hit && bus.Req0);
    case (st_q)
      GRANT0:  st_d = !rel0 ? GRANT0 : bus.Req1 ? GRANT1 : IDLE;
      GRANT1:  st_d = !rel1 ? GRANT1 : bus.Req0 ? GRANT0 : IDLE;
      default: st_d = (bus.Req0 && (!bus.Req1 || last_q)) ? GRANT0 :
                      bus.Req1 ? GRANT1 : IDLE;
    endcase
    entry   = (st_d != st_q);
    cnt_d   = entry ? 4'd0 : (st_q == IDLE) ? cnt_q : cnt_inc;
    last_d  = (entry && st_d == GRANT0) ? 1'b0 :
              (entry && st_d == GRANT1) ? 1'b1 : last_q;
    s_d     = (st_q == GRANT0) ? 1'b0 : (st_q == GRANT1) ? 1'b1 : s_q;
    dalja_d = (st_q == GRANT0) ? bus.Hyrja0 : (st_q == GRANT1) ? bus.Hyrja1 : dalja_q;
    valid_d = (st_q != IDLE);
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st_q    <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      s_q     <= 1'b0;
      dalja_q <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= (st_d == GRANT0);
      gnt1_q  <= (st_d == GRANT1);
      s_q     <= s_d;
      dalja_q <= dalja_d;
      valid_q <= valid_d;
    end
  end
  assign bus.Gnt0  = gnt0_q;
  assign bus.Gnt1  = gnt1_q;
  assign bus.S     = s_q;
  assign bus.Dalja = dalja_q;
  assign bus.Valid = valid_q;
endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// tb_mux_arbiter_2to1: directed vectors with a data scoreboard for mux_arbiter_2to1
module tb_mux_arbiter_2to1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mon_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] q[$];
  logic [4:0] held = 5'h0;
  logic [4:0] e;
  mux_arbiter_2to1_if bus();
  mux_arbiter_2to1 #(.MAX_HOLD(8)) dut (.Clock(clk), .Resetn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // eg is the {Gnt1,Gnt0} expected during the cycle these inputs are applied;
  // the holder's data is captured at the following edge, so it is queued now.
  task automatic row(input logic r0, r1, d0, d1, input logic [3:0] h0, h1, input logic [1:0] eg);
    @(negedge clk);
    chk("gnt", int'({bus.Gnt1, bus.Gnt0}), int'(eg));
    if (eg == 2'b01) q.push_back({1'b0, h0});
    if (eg == 2'b10) q.push_back({1'b1, h1});
    bus.Req0 = r0; bus.Req1 = r1; bus.Done0 = d0; bus.Done1 = d1;
    bus.Hyrja0 = h0; bus.Hyrja1 = h1;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.Valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("data", int'({bus.S, bus.Dalja}), int'(e));
          held = e;
        end
      end else
        chk("idle_hold", int'({bus.S, bus.Dalja}), int'(held));
    end
  end
  initial begin
    bus.Req0 = 0; bus.Req1 = 0; bus.Done0 = 0; bus.Done1 = 0;
    bus.Hyrja0 = 0; bus.Hyrja1 = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'({bus.Gnt1, bus.Gnt0}), 0);
    chk("rst_valid", int'(bus.Valid), 0);
    chk("rst_data", int'({bus.S, bus.Dalja}), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    row(1, 1, 0, 0, 4'h0, 4'h0, 2'b00);
    for (int i = 1; i <= 7; i++) row(1, 1, 0, 0, 4'(i), 4'(15 - i), 2'b01);
    for (int i = 0; i < 20; i++) row(0, 1, 0, 0, 4'h0, 4'(i), 2'b10);
    row(1, 1, 0, 0, 4'h3, 4'h5, 2'b10);
    row(0, 0, 0, 0, 4'h6, 4'h0, 2'b01);
    row(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);
    row(0, 1, 0, 0, 4'h0, 4'h0, 2'b00);
    row(1, 1, 0, 0, 4'h1, 4'h6, 2'b10);
    row(1, 1, 0, 0, 4'h2, 4'h7, 2'b10);
    row(1, 1, 0, 1, 4'h3, 4'h8, 2'b10);
    row(1, 0, 1, 0, 4'h9, 4'h0, 2'b01);
    row(1, 0, 0, 0, 4'h4, 4'h0, 2'b00);
    row(0, 0, 0, 0, 4'hA, 4'h0, 2'b01);
    row(1, 1, 0, 0, 4'h0, 4'h0, 2'b00);
    row(0, 1, 1, 0, 4'h0, 4'hC, 2'b10);
    row(0, 1, 1, 0, 4'h0, 4'hD, 2'b10);
    row(0, 0, 0, 0, 4'h0, 4'hE, 2'b10);
    row(0, 0, 0, 0, 4'h0, 4'h0, 2'b00);
    @(negedge clk);
    #1 chk("sb_empty", q.size(), 0);
    mon_en = 1'b0;
    bus.Req0 = 1; bus.Hyrja0 = 4'hB;
    @(negedge clk);
    chk("pre_rst_gnt0", int'(bus.Gnt0), 1);
    @(negedge clk);
    chk("pre_rst_data", int'({bus.Valid, bus.Dalja}), int'({1'b1, 4'hB}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", int'({bus.Gnt1, bus.Gnt0}), 0);
    chk("async_valid", int'(bus.Valid), 0);
    chk("async_data", int'({bus.S, bus.Dalja}), 0);
    @(negedge clk);
    rst_n = 1'b1; bus.Req1 = 1;
    #1 chk("rel_no_change", int'({bus.Gnt1, bus.Gnt0}), 0);
    @(negedge clk);
    chk("rel_tie_gnt0", int'({bus.Gnt1, bus.Gnt0}), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
